// File: rtl/sccb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | sccb_pkg : shared types and constants for the SCCB slave model   |
// | Rev 1.0  : initial release                                        |
// +------------------------------------------------------------------+
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ID        = 4'd1,
        ST_ID_X      = 4'd2,
        ST_SUB       = 4'd3,
        ST_SUB_X     = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_X   = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_NA  = 4'd8,
        ST_WAIT_STOP = 4'd9
    } sccb_slv_state_e;

    localparam logic [7:0] c_dev_id_default = 8'h42;
    localparam int         c_rw_bit         = 0;

endpackage
`default_nettype wire

// File: rtl/sccb_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | sccb_sync_edge : 2-FF synchroniser with rise/fall pulse outputs   |
// | Rev 1.0        : initial release                                  |
// +------------------------------------------------------------------+
module sccb_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] r_sh;

    // Reset to the idle bus level so no spurious edge follows reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh <= 3'b111;
        end else begin
            r_sh <= {r_sh[1:0], din};
        end
    end

    assign level = r_sh[1];
    assign rise  = r_sh[1] & ~r_sh[2];
    assign fall  = ~r_sh[1] & r_sh[2];

endmodule
`default_nettype wire

// File: rtl/sccb_slave_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | sccb_slave_regfile : OV7670-style SCCB responder + register file  |
// | Optional: SCCB_ACK_EN drives I2C-style ACK on the X bits.         |
// | Rev 1.0            : initial release                              |
// +------------------------------------------------------------------+
module sccb_slave_regfile
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ID    = c_dev_id_default,
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sccb_clk,
    inout  wire               io_sio_d,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [7:0]        host_rdata,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    localparam int c_depth = 2 ** ADDR_W;

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;

    sccb_sync_edge u_sync_scl (
        .clk   (clk),
        .reset (reset),
        .din   (sccb_clk),
        .level (w_scl_lvl),
        .rise  (w_scl_rise),
        .fall  (w_scl_fall)
    );

    sccb_sync_edge u_sync_sda (
        .clk   (clk),
        .reset (reset),
        .din   (io_sio_d),
        .level (w_sda_lvl),
        .rise  (w_sda_rise),
        .fall  (w_sda_fall)
    );

    sccb_slv_state_e   r_state, w_state_nxt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [ADDR_W-1:0] r_addr_ptr;
    logic [7:0]        r_rd_byte;
    logic              r_is_read;
    logic              r_sda_low;
    logic              r_wr_strobe;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_host_rdata;
    logic [7:0]        r_regs [c_depth];

    logic       w_start, w_stop, w_bit_evt, w_last_bit, w_id_ok;
    logic       w_commit, w_drive_low;
    logic [7:0] w_byte;

    assign w_start    = w_sda_fall & w_scl_lvl;
    assign w_stop     = w_sda_rise & w_scl_lvl;
    assign w_bit_evt  = w_scl_rise & ~w_start & ~w_stop;
    assign w_last_bit = (r_bit_cnt == 3'd7);
    assign w_byte     = {r_shift[6:0], w_sda_lvl};
    assign w_id_ok    = (w_byte[7:1] == DEV_ID[7:1]);
    assign w_commit   = w_bit_evt & (r_state == ST_WDATA) & w_last_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = ST_IDLE;
        end else if (w_start) begin
            w_state_nxt = ST_ID;
        end else if (w_scl_rise) begin
            case (r_state)
                ST_ID:       if (w_last_bit) w_state_nxt = w_id_ok ? ST_ID_X : ST_WAIT_STOP;
                ST_ID_X:     w_state_nxt = r_is_read ? ST_RDATA : ST_SUB;
                ST_SUB:      if (w_last_bit) w_state_nxt = ST_SUB_X;
                ST_SUB_X:    w_state_nxt = ST_WDATA;
                ST_WDATA:    if (w_last_bit) w_state_nxt = ST_WDATA_X;
                ST_WDATA_X:  w_state_nxt = ST_WAIT_STOP;
                ST_RDATA:    if (w_last_bit) w_state_nxt = ST_RDATA_NA;
                ST_RDATA_NA: w_state_nxt = ST_WAIT_STOP;
                default:     w_state_nxt = r_state;
            endcase
        end
    end

    // Level to present on SIO_D from the next SIO_C fall onward.
    always_comb begin
        w_drive_low = 1'b0;
        case (r_state)
            ST_RDATA:    w_drive_low = ~r_rd_byte[7];
`ifdef SCCB_ACK_EN
            ST_ID_X,
            ST_SUB_X,
            ST_WDATA_X:  w_drive_low = 1'b1;
`endif
            default:     w_drive_low = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_addr_ptr  <= '0;
            r_rd_byte   <= 8'h00;
            r_is_read   <= 1'b0;
            r_sda_low   <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
        end else begin
            r_wr_strobe <= w_commit;
            if (w_start || w_stop) begin
                r_bit_cnt <= 3'd0;
                r_sda_low <= 1'b0;
            end else begin
                if (w_scl_rise) begin
                    if (r_state == ST_ID || r_state == ST_SUB ||
                        r_state == ST_WDATA || r_state == ST_RDATA) begin
                        r_shift   <= w_byte;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    if (r_state == ST_ID && w_last_bit) begin
                        r_is_read <= w_byte[c_rw_bit];
                    end
                    if (r_state == ST_SUB && w_last_bit) begin
                        r_addr_ptr <= w_byte[ADDR_W-1:0];
                    end
                    if (r_state == ST_ID_X && r_is_read) begin
                        r_rd_byte <= r_regs[r_addr_ptr];
                    end
                    if (r_state == ST_RDATA) begin
                        r_rd_byte <= {r_rd_byte[6:0], 1'b0};
                    end
                    if (w_commit) begin
                        r_wr_addr <= r_addr_ptr;
                        r_wr_data <= w_byte;
                    end
                end
                if (w_scl_fall) begin
                    r_sda_low <= w_drive_low;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_regs[i] <= RESET_VAL;
            end
            r_host_rdata <= 8'h00;
        end else begin
            if (w_commit) begin
                r_regs[r_addr_ptr] <= w_byte;
            end
            r_host_rdata <= r_regs[host_addr];
        end
    end

    assign io_sio_d   = r_sda_low ? 1'b0 : 1'bz;
    assign host_rdata = r_host_rdata;
    assign wr_strobe  = r_wr_strobe;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
